// File: rtl/reaction_timer_pkg.sv
// Shared definitions for the reaction timer: FSM state encoding, the
// saturation limit of the reaction counter and the LFSR polynomial.
package reaction_timer_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DELAY   = 3'd1,
    S_REACT   = 3'd2,
    S_DONE    = 3'd3,
    S_EARLY   = 3'd4,
    S_TIMEOUT = 3'd5
  } state_t;

  localparam logic [13:0] REACTION_MAX = 14'd9999;

  // x^7 + x^6 + 1: feedback is the XOR of bits 6 and 5.
  localparam logic [6:0] LFSR_TAPS = 7'b110_0000;
  localparam logic [6:0] LFSR_SEED = 7'h01;

  // Shift left, feedback enters at bit 0. A nonzero seed never reaches 0.
  function automatic logic [6:0] lfsr_next(input logic [6:0] q);
    return {q[5:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/reaction_timer_btn_sync_edge.sv
// Push-button conditioning: two-flop synchroniser followed by a rising-edge
// detector, so each low-to-high transition of the raw button yields exactly
// one single-cycle pulse however long the button is held.
// Ports:
//   clk      in  system clock
//   areset   in  asynchronous active-high reset
//   i_btn    in  raw asynchronous button, active-high
//   o_press  out one-cycle pulse, valid two edges after i_btn rises
module btn_sync_edge (
  input  logic clk,
  input  logic areset,
  input  logic i_btn,
  output logic o_press
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_press = r_sync2 & ~r_prev;

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time tester. A press arms a trial; after MIN_DELAY plus a
// pseudo-random number of ms the LED lights, and the ms count until the
// next press is reported on `reaction` (saturating at 9999).
// Ports:
//   clk       in  system clock
//   areset    in  asynchronous active-high reset
//   user_btn  in  raw push-button, active-high
//   led       out stimulus LED, high only in REACT
//   testL     out current LFSR value (debug)
//   state     out current FSM state code (debug)
//   reaction  out measured reaction time in ms
module reaction_timer
  import reaction_timer_pkg::*;
#(
  parameter int TICK_DIV   = 100000,
  parameter int MIN_DELAY  = 1000,
  parameter int RAND_SCALE = 16
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        user_btn,
  output logic        led,
  output logic [6:0]  testL,
  output logic [2:0]  state,
  output logic [13:0] reaction
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t        r_state;
  state_t        w_next_state;
  logic          r_led;
  logic          w_next_led;
  logic [13:0]   r_reaction;
  logic [13:0]   w_next_reaction;
  logic [13:0]   r_delay;
  logic [13:0]   w_next_delay;
  logic [PW-1:0] r_presc;
  logic [6:0]    r_lfsr;
  logic          w_press;
  logic          w_tick;
  logic          w_presc_clr;
  logic [13:0]   w_delay_load;

  btn_sync_edge u_btn (
    .clk     (clk),
    .areset  (areset),
    .i_btn   (user_btn),
    .o_press (w_press)
  );

  assign w_tick       = (r_presc == PW'(TICK_DIV - 1));
  assign w_delay_load = 14'(MIN_DELAY + int'(r_lfsr) * RAND_SCALE);

  // The ms grid restarts whenever a timed phase begins, so the first tick
  // of DELAY/REACT lands a full TICK_DIV cycles after entry.
  assign w_presc_clr  = (w_next_state != r_state) &&
                        ((w_next_state == S_DELAY) || (w_next_state == S_REACT));

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_presc <= '0;
      r_lfsr  <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
      if (w_presc_clr || w_tick) r_presc <= '0;
      else                       r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state    <= S_IDLE;
      r_led      <= 1'b0;
      r_reaction <= '0;
      r_delay    <= '0;
    end else begin
      r_state    <= w_next_state;
      r_led      <= w_next_led;
      r_reaction <= w_next_reaction;
      r_delay    <= w_next_delay;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_next_led      = r_led;
    w_next_reaction = r_reaction;
    w_next_delay    = r_delay;
    case (r_state)
      S_IDLE, S_DONE, S_EARLY, S_TIMEOUT: begin
        w_next_led = 1'b0;
        if (r_state == S_EARLY) w_next_reaction = '0;
        if (w_press) begin
          w_next_state    = S_DELAY;
          w_next_delay    = w_delay_load;
          w_next_reaction = '0;
        end
      end
      S_DELAY: begin
        w_next_led = 1'b0;
        // A press always wins over a same-cycle expiry.
        if (w_press) begin
          w_next_state    = S_EARLY;
          w_next_reaction = '0;
        end else if (w_tick) begin
          if (r_delay <= 14'd1) begin
            w_next_state    = S_REACT;
            w_next_delay    = '0;
            w_next_led      = 1'b1;
            w_next_reaction = '0;
          end else begin
            w_next_delay = r_delay - 14'd1;
          end
        end
      end
      S_REACT: begin
        w_next_led = 1'b1;
        // A press freezes the count; a coincident tick is dropped.
        if (w_press) begin
          w_next_state = S_DONE;
          w_next_led   = 1'b0;
        end else if (w_tick) begin
          if (r_reaction >= REACTION_MAX - 14'd1) begin
            w_next_state    = S_TIMEOUT;
            w_next_reaction = REACTION_MAX;
            w_next_led      = 1'b0;
          end else begin
            w_next_reaction = r_reaction + 14'd1;
          end
        end
      end
      default: begin
        w_next_state    = S_IDLE;
        w_next_led      = 1'b0;
        w_next_reaction = '0;
      end
    endcase
  end

  assign led      = r_led;
  assign testL    = r_lfsr;
  assign state    = r_state;
  assign reaction = r_reaction;

endmodule

// File: tb/tb_reaction_timer.sv
module tb_reaction_timer;

  logic        clk = 1'b0;
  logic        areset;
  logic        btn1, btn2;
  logic        led1, led2;
  logic [6:0]  testL1, testL2;
  logic [2:0]  state1, state2;
  logic [13:0] reaction1, reaction2;

  int total = 0;
  int bad   = 0;

  logic [6:0]  m_lfsr;
  logic [6:0]  cap_l;
  int          cnt;
  int          n_delay;
  bit          seen_early;
  logic [2:0]  prev_state;
  logic [13:0] prev_r;

  always #5 clk = ~clk;

  reaction_timer #(.TICK_DIV(10), .MIN_DELAY(2), .RAND_SCALE(1)) u_dut1 (
    .clk(clk), .areset(areset), .user_btn(btn1),
    .led(led1), .testL(testL1), .state(state1), .reaction(reaction1)
  );

  reaction_timer #(.TICK_DIV(2), .MIN_DELAY(2), .RAND_SCALE(1)) u_dut2 (
    .clk(clk), .areset(areset), .user_btn(btn2),
    .led(led2), .testL(testL2), .state(state2), .reaction(reaction2)
  );

  // Reference LFSR: x^7+x^6+1, seed 1, shifting left.
  always @(posedge clk or posedge areset) begin
    if (areset) m_lfsr <= 7'h01;
    else        m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse held for two cycles; returns on the negedge after the FSM acted.
  task automatic press1();
    btn1 = 1'b1;
    repeat (2) @(negedge clk);
    cap_l = m_lfsr;
    btn1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic press2();
    btn2 = 1'b1;
    repeat (2) @(negedge clk);
    cap_l = m_lfsr;
    btn2 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    areset = 1'b1;
    btn1   = 1'b0;
    btn2   = 1'b0;

    // Reset and LFSR stepping
    @(negedge clk);
    areset = 1'b0;
    check("rst_state", 32'(state1), 0);
    check("rst_led", 32'(led1), 0);
    check("rst_reaction", 32'(reaction1), 0);
    check("rst_testL", 32'(testL1), 32'h01);
    @(negedge clk);
    check("lfsr_1", 32'(testL1), 32'h02);
    @(negedge clk);
    check("lfsr_2", 32'(testL1), 32'h04);

    // Normal trial
    press1();
    check("trial_delay_state", 32'(state1), 1);
    check("trial_led_off", 32'(led1), 0);
    cnt = 0;
    while (led1 !== 1'b1 && cnt < 1400) begin
      @(negedge clk);
      cnt++;
    end
    check("trial_led_time", 32'((cnt >= 10*(2+int'(cap_l)) - 2) && (cnt <= 10*(2+int'(cap_l)) + 2)), 1);
    check("trial_react_state", 32'(state1), 2);
    check("trial_react_zero", 32'(reaction1), 0);
    repeat (100) @(negedge clk);
    press1();
    check("trial_done_state", 32'(state1), 3);
    check("trial_done_led", 32'(led1), 0);
    check("trial_done_reaction", 32'(reaction1), 10);
    repeat (50) @(negedge clk);
    check("trial_hold_reaction", 32'(reaction1), 10);
    check("trial_hold_state", 32'(state1), 3);
    check("lfsr_model", 32'(testL1), 32'(m_lfsr));

    // Early press, then restart from EARLY
    press1();
    check("early_arm_state", 32'(state1), 1);
    check("early_arm_cleared", 32'(reaction1), 0);
    repeat (5) @(negedge clk);
    press1();
    check("early_state", 32'(state1), 4);
    check("early_led", 32'(led1), 0);
    check("early_reaction", 32'(reaction1), 0);
    press1();
    check("early_restart_state", 32'(state1), 1);

    // Async reset in the middle of REACT
    cnt = 0;
    while (led1 !== 1'b1 && cnt < 1400) begin
      @(negedge clk);
      cnt++;
    end
    check("async_led_on", 32'(led1), 1);
    repeat (30) @(negedge clk);
    check("async_pre_reaction", 32'(reaction1), 3);
    #2 areset = 1'b1;
    #1;
    check("async_state", 32'(state1), 0);
    check("async_led", 32'(led1), 0);
    check("async_reaction", 32'(reaction1), 0);
    check("async_testL", 32'(testL1), 32'h01);
    @(negedge clk);
    areset = 1'b0;

    // Held button gives a single event
    btn1       = 1'b1;
    n_delay    = 0;
    seen_early = 1'b0;
    prev_state = 3'd0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (state1 == 3'd4) seen_early = 1'b1;
      if (state1 == 3'd1 && prev_state != 3'd1) n_delay++;
      prev_state = state1;
    end
    check("held_one_delay", 32'(n_delay), 1);
    check("held_no_early", 32'(seen_early), 0);
    btn1 = 1'b0;
    repeat (5) @(negedge clk);
    check("held_release_no_early", 32'(state1 == 3'd4), 0);

    // Timeout on the fast-tick instance
    press2();
    check("to_delay_state", 32'(state2), 1);
    cnt = 0;
    while (led2 !== 1'b1 && cnt < 1400) begin
      @(negedge clk);
      cnt++;
    end
    check("to_led_on", 32'(led2), 1);
    check("to_led_time", 32'((cnt >= 2*(2+int'(cap_l)) - 2) && (cnt <= 2*(2+int'(cap_l)) + 2)), 1);
    prev_r = reaction2;
    cnt = 0;
    while (state2 !== 3'd5 && cnt < 25000) begin
      prev_r = reaction2;
      @(negedge clk);
      cnt++;
    end
    check("to_state", 32'(state2), 5);
    check("to_reaction", 32'(reaction2), 9999);
    check("to_prev_reaction", 32'(prev_r), 9998);
    check("to_led_off", 32'(led2), 0);
    repeat (20) @(negedge clk);
    check("to_hold_reaction", 32'(reaction2), 9999);
    check("to_hold_state", 32'(state2), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
Human reaction-time tester for an FPGA board. A button press arms a trial. After a pseudo-random delay the LED lights. The block then counts milliseconds until the next press and presents the result as a 14-bit binary value (0..9999) for a downstream display driver. State and LFSR value are exported for debug.

Parameters:
TICK_DIV, 100000, clock cycles per 1 ms tick (100 MHz clock); must be >= 2.
MIN_DELAY, 1000, fixed part of the pre-LED delay, in ms ticks.
RAND_SCALE, 16, ms ticks per LFSR count added to the delay; MIN_DELAY + 127*RAND_SCALE must be <= 16383.

Ports:
clk  in  1  system clock, all logic on rising edge.
areset  in  1  asynchronous, active-high reset.
user_btn  in  1  raw asynchronous push-button, active-high.
led  out  1  stimulus LED; high only in REACT.
testL  out  7  current LFSR value (debug).
state  out  3  current FSM state code (debug).
reaction  out  14  measured reaction time in ms, saturating at 9999.

Behaviour:
- Reset (areset=1, asynchronous):
  - state=IDLE(0), led=0, reaction=0, testL=7'h01.
  - Sync flops, edge register, prescaler and delay counter cleared.
- Button path:
  - 2-flop synchroniser, then a rising-edge detector: press = sync & ~prev.
  - A press acts on the FSM at the third rising clk edge after user_btn rises.
  - One press per low-to-high transition, so a held button gives one event. A 2-cycle-wide pulse must be detected.
- LFSR:
  - 7-bit Fibonacci LFSR, x^7+x^6+1, seed 7'h01.
  - Advances every clock in every state; never 0. testL = LFSR.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick pulses for one cycle when it equals TICK_DIV-1, then wraps to 0.
  - Forced to 0 on every entry to DELAY or REACT.
- FSM state codes: IDLE=0, DELAY=1, REACT=2, DONE=3, EARLY=4, TIMEOUT=5. Codes 6 and 7 go to IDLE next cycle.
  - IDLE: led=0. On press: go to DELAY, load delay counter = MIN_DELAY + LFSR*RAND_SCALE (LFSR sampled that cycle), clear reaction.
  - DELAY: delay counter decrements on each tick.
    - Counter reaches 0 (on a tick): go to REACT; reaction=0, led=1 registered.
    - Press before that: go to EARLY. Press has priority over expiry in the same cycle.
  - REACT: reaction increments by 1 on each tick.
    - Press: go to DONE, led=0, reaction frozen. Press has priority over a same-cycle tick; that tick is not counted.
    - If reaction reaches 9999 with no press: go to TIMEOUT, reaction=9999, led=0.
  - DONE, EARLY, TIMEOUT: led=0, reaction held (EARLY forces reaction=0). On press: start a new trial exactly as from IDLE (go to DELAY, reload delay, clear reaction).
- Outputs are registered, with no combinational path from user_btn.
- Reset mid-trial returns to IDLE immediately, with every output at its reset value.

Decomposition:
- Package reaction_timer_pkg: state enum (3-bit, codes above), constant REACTION_MAX=9999, LFSR tap constant.
- One sub-module, btn_sync_edge: 2-flop synchroniser plus rising-edge pulse, with async reset.
- Prescaler, LFSR and FSM live in the top level.

Test Plan:
All scenarios use TICK_DIV=10, MIN_DELAY=2, RAND_SCALE=1 unless stated.
1. Reset: assert areset for 1 cycle, then release -> state=0, led=0, reaction=0, testL=7'h01; testL then steps 01,02,04,... per the LFSR.
2. Normal trial: 2-cycle press in IDLE -> state=1. led rises after (2+LFSR_sample)*10 cycles (+-2). Press 100 cycles after led rises -> state=3, led=0, reaction=10, held.
3. Early press: press, then press again 5 cycles after state=1 -> state=4, led=0, reaction=0. A further press -> state=1.
4. Timeout: with TICK_DIV=2, never press after led rises -> reaction saturates at 9999, state=5, led=0.
5. Held button: hold user_btn high for 500 cycles from IDLE -> exactly one transition (to DELAY); no EARLY.
6. Async reset mid-REACT: assert areset between clock edges -> state=0, led=0, reaction=0 without waiting for a clk edge.
